// File: rtl/data_sram_responder.sv
// Responder for the core data-memory port. It serves one request at a time
// from a single-port synchronous SRAM macro whose read latency is set by a
// parameter.
//
// Ports:
//   clk, rstb                      clock; asynchronous active-low reset
//   data_memory*                   core request (address, lanes, enable, we, wdata)
//                                  and response (rdata, busy, fault)
//   sram_csb/web/wmask/addr/din    registered SRAM strobes, all active for
//                                  exactly one cycle per access
//   sram_dout                      SRAM read data
module data_sram_responder #(
    parameter int unsigned ADDRESS_WIDTH = 11,
    parameter logic [31:0] BASE_ADDRESS  = 32'h0000_0000,
    parameter int unsigned SRAM_LATENCY  = 1  // legal range 1..3
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic [31:0]              data_memoryAddress,
    input  logic [3:0]               data_memoryByteSelect,
    input  logic                     data_memoryEnable,
    input  logic                     data_memoryWriteEnable,
    input  logic [31:0]              data_memoryDataWrite,
    output logic [31:0]              data_memoryDataRead,
    output logic                     data_memoryBusy,
    output logic                     data_memoryAccessFault,
    output logic                     sram_csb,
    output logic                     sram_web,
    output logic [3:0]               sram_wmask,
    output logic [ADDRESS_WIDTH-3:0] sram_addr,
    output logic [31:0]              sram_din,
    input  logic [31:0]              sram_dout
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StRespond} state_e;

    state_e                     state_q, state_d;
    logic [3:0]                 be_q, be_d;
    logic                       we_q, we_d;
    logic                       fault_q, fault_d;
    logic [31:0]                rdata_q, rdata_d;
    logic [1:0]                 cnt_q, cnt_d;
    logic                       csb_q, csb_d;
    logic                       web_q, web_d;
    logic [3:0]                 wmask_q, wmask_d;
    logic [ADDRESS_WIDTH-3:0]   saddr_q, saddr_d;
    logic [31:0]                din_q, din_d;

    logic                       in_range;
    logic [31:0]                lane_mask;
    logic                       unused_addr_bits;

    // Window decode covers every upper bit, so addresses never alias back in.
    assign in_range = data_memoryAddress[31:ADDRESS_WIDTH] == BASE_ADDRESS[31:ADDRESS_WIDTH];
    assign lane_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
    assign unused_addr_bits = ^data_memoryAddress[1:0];

    always_comb begin
        state_d = state_q;
        be_d    = be_q;
        we_d    = we_q;
        fault_d = fault_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        csb_d   = csb_q;
        web_d   = web_q;
        wmask_d = wmask_q;
        saddr_d = saddr_q;
        din_d   = din_q;
        unique case (state_q)
            StIdle: begin
                if (data_memoryEnable) begin
                    be_d = data_memoryByteSelect;
                    we_d = data_memoryWriteEnable;
                    if (!in_range || data_memoryByteSelect == 4'b0000) begin
                        fault_d = 1'b1;
                        state_d = StRespond;
                    end else begin
                        // Strobes are registered here so they are live during ISSUE.
                        csb_d   = 1'b0;
                        web_d   = !data_memoryWriteEnable;
                        wmask_d = data_memoryWriteEnable ? data_memoryByteSelect : 4'b0000;
                        saddr_d = data_memoryAddress[ADDRESS_WIDTH-1:2];
                        din_d   = data_memoryDataWrite;
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                csb_d = 1'b1;
                web_d = 1'b1;
                if (we_q) begin
                    state_d = StRespond;
                end else begin
                    cnt_d   = 2'(SRAM_LATENCY);
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    rdata_d = sram_dout & lane_mask;
                    state_d = StRespond;
                end
            end
            StRespond: begin
                fault_d = 1'b0;
                rdata_d = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= StIdle;
            be_q    <= '0;
            we_q    <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            wmask_q <= '0;
            saddr_q <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            be_q    <= be_d;
            we_q    <= we_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            wmask_q <= wmask_d;
            saddr_q <= saddr_d;
            din_q   <= din_d;
        end
    end

    // Busy is forced low during reset so the core never sees a stall it cannot clear.
    always_comb begin
        data_memoryBusy = 1'b0;
        if (rstb) begin
            unique case (state_q)
                StIdle:    data_memoryBusy = data_memoryEnable;
                StIssue:   data_memoryBusy = 1'b1;
                StWait:    data_memoryBusy = 1'b1;
                StRespond: data_memoryBusy = 1'b0;
                default:   data_memoryBusy = 1'b0;
            endcase
        end
    end

    // rdata_q and fault_q are only non-zero in RESPOND.
    assign data_memoryDataRead    = rdata_q;
    assign data_memoryAccessFault = fault_q;
    assign sram_csb               = csb_q;
    assign sram_web               = web_q;
    assign sram_wmask             = wmask_q;
    assign sram_addr              = saddr_q;
    assign sram_din               = din_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: two instances (SRAM latency 1 and 3), each with
// its own SRAM model whose output is only meaningful for one cycle.
module tb_data_sram_responder;

    logic        clk;
    logic        rstb;
    logic [31:0] req_addr  [2];
    logic [3:0]  req_be    [2];
    logic        req_en    [2];
    logic        req_we    [2];
    logic [31:0] req_wdata [2];
    logic [31:0] rdata     [2];
    logic        busy      [2];
    logic        fault     [2];
    logic        sram_csb  [2];
    logic        sram_web  [2];
    logic [3:0]  sram_wmask[2];
    logic [8:0]  sram_addr [2];
    logic [31:0] sram_din  [2];
    logic [31:0] sram_dout [2];

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] ref_mem [2][512];
    int unsigned widx [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned Lat = (g == 0) ? 1 : 3;
        logic [31:0] mem    [512];
        logic [31:0] pipe_d [3];
        logic        pipe_v [3];

        data_sram_responder #(
            .ADDRESS_WIDTH(11),
            .BASE_ADDRESS (32'h0000_0000),
            .SRAM_LATENCY (Lat)
        ) u_dut (
            .clk                   (clk),
            .rstb                  (rstb),
            .data_memoryAddress    (req_addr[g]),
            .data_memoryByteSelect (req_be[g]),
            .data_memoryEnable     (req_en[g]),
            .data_memoryWriteEnable(req_we[g]),
            .data_memoryDataWrite  (req_wdata[g]),
            .data_memoryDataRead   (rdata[g]),
            .data_memoryBusy       (busy[g]),
            .data_memoryAccessFault(fault[g]),
            .sram_csb              (sram_csb[g]),
            .sram_web              (sram_web[g]),
            .sram_wmask            (sram_wmask[g]),
            .sram_addr             (sram_addr[g]),
            .sram_din              (sram_din[g]),
            .sram_dout             (sram_dout[g])
        );

        always @(posedge clk) begin
            pipe_v[0] <= !sram_csb[g] && sram_web[g];
            pipe_d[0] <= mem[sram_addr[g]];
            for (int i = 1; i < 3; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
            if (!sram_csb[g] && !sram_web[g]) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_wmask[g][b]) mem[sram_addr[g]][8*b +: 8] <= sram_din[g][8*b +: 8];
                end
            end
        end

        // Garbage outside the valid cycle exposes captures on the wrong edge.
        assign sram_dout[g] = pipe_v[Lat-1] ? pipe_d[Lat-1] : 32'hA5A5_5A5A;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) if (be[b]) m = m + (32'hFF << (8 * b));
        return m;
    endfunction

    // One request on instance s; expectations come from the window/lane rules.
    task automatic do_req(input int s, input logic [31:0] a, input logic [3:0] be,
                          input logic we, input logic [31:0] wd,
                          output logic [31:0] rd, output logic flt);
        int          lat_exp, k, csb_cnt;
        logic        flt_exp, done;
        logic [31:0] rd_exp;
        flt_exp = (a >= 32'h800) || (be == 4'b0000);
        lat_exp = flt_exp ? 1 : (we ? 2 : 2 + ((s == 0) ? 1 : 3));
        rd_exp  = (flt_exp || we) ? 32'h0 : (ref_mem[s][a[10:2]] & lanes(be));
        if (!flt_exp && we)
            ref_mem[s][a[10:2]] = (ref_mem[s][a[10:2]] & ~lanes(be)) | (wd & lanes(be));
        @(posedge clk);
        #1;
        req_addr[s] = a; req_be[s] = be; req_we[s] = we; req_wdata[s] = wd; req_en[s] = 1'b1;
        k = 0; csb_cnt = 0; done = 1'b0; rd = '0; flt = 1'b0;
        while (!done && k <= 20) begin
            @(negedge clk);
            if (!sram_csb[s]) begin
                csb_cnt++;
                chk("issue_web", 32'(sram_web[s]), 32'(!we));
                chk("issue_wmask", 32'(sram_wmask[s]), we ? 32'(be) : 32'h0);
                chk("issue_addr", 32'(sram_addr[s]), 32'(a[10:2]));
                chk("issue_din", sram_din[s], wd);
            end
            if (!busy[s]) begin
                done = 1'b1;
                rd   = rdata[s];
                flt  = fault[s];
                chk("resp_latency", k, lat_exp);
                chk("resp_rdata", rdata[s], rd_exp);
                chk("resp_fault", 32'(fault[s]), 32'(flt_exp));
            end else begin
                chk("busy_rdata_zero", rdata[s], 32'h0);
                chk("busy_fault_zero", 32'(fault[s]), 32'h0);
            end
            k++;
        end
        chk("resp_seen", 32'(done), 32'h1);
        chk("csb_pulses", csb_cnt, flt_exp ? 0 : 1);
        req_en[s] = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, a;
        logic        flt, we;
        logic [3:0]  be;
        int          mode;

        for (int s = 0; s < 2; s++) begin
            req_addr[s] = '0; req_be[s] = '0; req_en[s] = 1'b1;
            req_we[s] = 1'b0; req_wdata[s] = '0;
        end
        for (int i = 0; i < 16; i++) widx[i] = (i * 37) % 512;

        // Reset values, with enable high to prove busy is held low in reset.
        rstb = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy[0]), 32'h0);
        chk("rst_csb", 32'(sram_csb[0]), 32'h1);
        chk("rst_web", 32'(sram_web[0]), 32'h1);
        chk("rst_wmask", 32'(sram_wmask[0]), 32'h0);
        chk("rst_addr", 32'(sram_addr[0]), 32'h0);
        chk("rst_din", sram_din[0], 32'h0);
        chk("rst_rdata", rdata[0], 32'h0);
        chk("rst_fault", 32'(fault[0]), 32'h0);
        req_en[0] = 1'b0; req_en[1] = 1'b0;
        rstb = 1'b1;

        // Latency 1: full write / read back.
        do_req(0, 32'h0000_0010, 4'b1111, 1'b1, 32'hDEAD_BEEF, rd, flt);
        do_req(0, 32'h0000_0010, 4'b1111, 1'b0, 32'h0, rd, flt);
        chk("readback_full", rd, 32'hDEAD_BEEF);
        // Byte-lane merge and masked read.
        do_req(0, 32'h0000_0020, 4'b1111, 1'b1, 32'h1122_3344, rd, flt);
        do_req(0, 32'h0000_0020, 4'b0010, 1'b1, 32'h0000_AA00, rd, flt);
        do_req(0, 32'h0000_0020, 4'b1111, 1'b0, 32'h0, rd, flt);
        chk("byte_merge", rd, 32'h1122_AA44);
        do_req(0, 32'h0000_0020, 4'b1100, 1'b0, 32'h0, rd, flt);
        chk("masked_read", rd, 32'h1122_0000);
        // Window edges and empty lane select.
        do_req(0, 32'h0000_0800, 4'b1111, 1'b0, 32'h0, rd, flt);
        chk("past_window_fault", 32'(flt), 32'h1);
        do_req(0, 32'h0000_0010, 4'b0000, 1'b1, 32'h1234_5678, rd, flt);
        chk("empty_be_fault", 32'(flt), 32'h1);
        do_req(0, 32'h0000_07FC, 4'b1111, 1'b1, 32'h5A5A_0F0F, rd, flt);
        do_req(0, 32'h0000_07FC, 4'b1111, 1'b0, 32'h0, rd, flt);
        chk("top_word", rd, 32'h5A5A_0F0F);
        do_req(0, 32'hFFFF_FFFC, 4'b1111, 1'b0, 32'h0, rd, flt);
        chk("wrap_fault", 32'(flt), 32'h1);
        do_req(0, 32'h0000_0010, 4'b1111, 1'b0, 32'h0, rd, flt);
        chk("no_write_on_fault", rd, 32'hDEAD_BEEF);

        // Latency 3: write then two back-to-back reads.
        do_req(1, 32'h0000_0040, 4'b1111, 1'b1, 32'hCAFE_F00D, rd, flt);
        do_req(1, 32'h0000_0040, 4'b1111, 1'b0, 32'h0, rd, flt);
        chk("lat3_read_a", rd, 32'hCAFE_F00D);
        do_req(1, 32'h0000_0040, 4'b0101, 1'b0, 32'h0, rd, flt);
        chk("lat3_read_b", rd, 32'h00FE_000D);

        // Reset during ISSUE drops the chip select at once.
        @(posedge clk); #1;
        req_addr[1] = 32'h40; req_be[1] = 4'hF; req_we[1] = 1'b0; req_en[1] = 1'b1;
        repeat (2) @(negedge clk);
        rstb = 1'b0; #1;
        chk("rst_issue_csb", 32'(sram_csb[1]), 32'h1);
        @(negedge clk); rstb = 1'b1; req_en[1] = 1'b0;

        // Reset during WAIT clears busy at once and leaves no stale response.
        @(posedge clk); #1;
        req_en[1] = 1'b1;
        repeat (3) @(negedge clk);
        rstb = 1'b0; #1;
        chk("rst_wait_busy", 32'(busy[1]), 32'h0);
        chk("rst_wait_csb", 32'(sram_csb[1]), 32'h1);
        @(negedge clk); rstb = 1'b1; req_en[1] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_rdata", rdata[1], 32'h0);
            chk("post_rst_fault", 32'(fault[1]), 32'h0);
            chk("post_rst_busy", 32'(busy[1]), 32'h0);
        end
        do_req(1, 32'h0000_0040, 4'b1111, 1'b0, 32'h0, rd, flt);
        chk("post_rst_read", rd, 32'hCAFE_F00D);

        // Randomized traffic over a preloaded set of words.
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++)
                do_req(s, widx[i] << 2, 4'b1111, 1'b1, $urandom, rd, flt);
            for (int n = 0; n < 60; n++) begin
                mode = $urandom_range(0, 9);
                a    = {21'h0, widx[$urandom_range(0, 15)][8:0], 2'($urandom_range(0, 3))};
                be   = 4'($urandom_range(1, 15));
                we   = 1'($urandom_range(0, 1));
                if (mode == 0) begin
                    a = $urandom;
                    if (a < 32'h800) a[11] = 1'b1;
                end else if (mode == 1) begin
                    be = 4'b0000;
                end
                do_req(s, a, be, we, $urandom, rd, flt);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
